// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the SR-latch pulse sequencer.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sr_rr_arbiter2.sv
// Two-way round-robin arbiter: grants one requester while enabled, then
// points priority at the other requester.
module sr_rr_arbiter2
  import sr_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (en_i) begin
      if (req_a_i && (!req_b_i || ptr_q == REQ_A)) gnt_a_o = 1'b1;
      else if (req_b_i)                             gnt_b_o = 1'b1;
    end
    ptr_d = ptr_q;
    if (gnt_a_o)      ptr_d = REQ_B;
    else if (gnt_b_o) ptr_d = REQ_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= REQ_A;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sr_latch_pulse_sequencer.sv
// Drives timed active-low set/reset pulses into a bank of NAND SR latches.
// Optional readback check of the latch Q after each pulse: VERIFY_READBACK_EN.
module sr_latch_pulse_sequencer
  import sr_seq_pkg::*;
#(
  parameter  int N_LATCH   = 4,
  parameter  int PULSE_CYC = 2,
  parameter  int GAP_CYC   = 1,
  localparam int IW        = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  input  logic [IW-1:0]      a_idx,
  input  logic               a_op,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [IW-1:0]      b_idx,
  input  logic               b_op,
  output logic               b_ready,
  output logic [N_LATCH-1:0] s_n,
  output logic [N_LATCH-1:0] r_n,
  input  logic [N_LATCH-1:0] q_in,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               op_q, op_d;
  logic [N_LATCH-1:0] s_n_q, s_n_d, r_n_q, r_n_d;
  logic               gnt_a, gnt_b;

  function automatic logic in_range(input logic [IW-1:0] i);
    return {1'b0, i} < (IW+1)'(N_LATCH);
  endfunction

  sr_rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q == IDLE),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_a) begin
          idx_d = a_idx; op_d = a_op; state_d = PULSE; cnt_d = '0;
        end else if (gnt_b) begin
          idx_d = b_idx; op_d = b_op; state_d = PULSE; cnt_d = '0;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          state_d = GAP; cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d = '0;
`ifdef VERIFY_READBACK_EN
          state_d = CHECK;
`else
          state_d = IDLE;
          done    = 1'b1;
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
      CHECK: begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from next state so the pins come straight off flops.
  always_comb begin
    s_n_d = '1;
    r_n_d = '1;
    if (state_d == PULSE && in_range(idx_d)) begin
      if (op_d == OP_SET) s_n_d[idx_d] = 1'b0;
      else                r_n_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= OP_CLR;
      s_n_q   <= '1;
      r_n_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      s_n_q   <= s_n_d;
      r_n_q   <= r_n_d;
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign s_n     = s_n_q;
  assign r_n     = r_n_q;
  assign busy    = (state_q != IDLE);

`ifdef VERIFY_READBACK_EN
  logic [N_LATCH-1:0] q_s1_q, q_s2_q;
  logic               err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1_q <= '0;
      q_s2_q <= '0;
      err_q  <= 1'b0;
    end else begin
      q_s1_q <= q_in;
      q_s2_q <= q_s1_q;
      if (state_q == CHECK && in_range(idx_q) && q_s2_q[idx_q] != op_q) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_qin;
  assign unused_qin = ^q_in;
  assign err        = 1'b0;
`endif

  a_no_race: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(~{s_n, r_n}) <= 1);

endmodule

// File: tb/tb_sr_latch_pulse_sequencer.sv
// Randomised self-checking bench for sr_latch_pulse_sequencer with a latch-bank model.
module tb_sr_latch_pulse_sequencer;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int P    = 2;
  localparam int G    = 1;
  localparam int NOPS = 1000;
`ifdef VERIFY_READBACK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [IW-1:0] a_idx = '0, b_idx = '0;
  logic          a_op = 1'b0, b_op = 1'b0;
  logic          a_ready, b_ready, busy, done, err;
  logic [N-1:0]  s_n, r_n, q_in;
  logic [N-1:0]  lat_q = '0;
  logic          stuck0 = 1'b0;

  int tests = 0;
  int fails = 0;

  sr_latch_pulse_sequencer #(.N_LATCH(N), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_idx(a_idx), .a_op(a_op), .a_ready(a_ready),
    .b_valid(b_valid), .b_idx(b_idx), .b_op(b_op), .b_ready(b_ready),
    .s_n(s_n), .r_n(r_n), .q_in(q_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // NAND latch bank: low s_n sets Q, low r_n clears it, otherwise hold.
  always @(s_n or r_n) begin
    for (int i = 0; i < N; i++) begin
      if (!s_n[i])      lat_q[i] = 1'b1;
      else if (!r_n[i]) lat_q[i] = 1'b0;
    end
  end
  assign q_in = stuck0 ? '0 : lat_q;

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({s_n, r_n} !== 8'hFF) begin
      fails++; $display("FAIL reset_outputs: got %h expected ff", {s_n, r_n});
    end
    tests++;
    if ({busy, err, done, a_ready, b_ready} !== 5'b0) begin
      fails++; $display("FAIL reset_status: got %b expected 00000", {busy, err, done, a_ready, b_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      tests++;
      if ({a_ready, b_ready, busy, done, s_n, r_n} !== {4'b0, 8'hFF}) begin
        fails++; $display("FAIL idle_quiet: got %h expected 0ff", {a_ready, b_ready, busy, done, s_n, r_n});
      end
    end
  endtask

  task automatic test_a_only;
    logic [N-1:0] es;
    @(negedge clk);
    a_valid = 1'b1; a_idx = 2'd2; a_op = 1'b1;
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      fails++; $display("FAIL a_only_grant: got %b expected 10", {a_ready, b_ready});
    end
    for (int k = 1; k <= P + G + CHK + 1; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      es = (k <= P) ? 4'b1011 : 4'b1111;
      tests++;
      if ({s_n, r_n, done, busy} !== {es, 4'b1111, (k == P + G + CHK), (k <= P + G + CHK)}) begin
        fails++;
        $display("FAIL a_only_cycle%0d: got %h expected %h", k, {s_n, r_n, done, busy},
                 {es, 4'b1111, (k == P + G + CHK), (k <= P + G + CHK)});
      end
    end
    tests++;
    if (lat_q[2] !== 1'b1) begin
      fails++; $display("FAIL a_only_latch: got %b expected 1", lat_q[2]);
    end
  endtask

  task automatic test_arbitration;
    int  k;
    logic got;
    apply_reset;
    @(negedge clk);
    a_valid = 1'b1; a_idx = 2'd1; a_op = 1'b1;
    b_valid = 1'b1; b_idx = 2'd1; b_op = 1'b0;
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      fails++; $display("FAIL arb_first_a: got %b expected 10", {a_ready, b_ready});
    end
    k = 0; got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      a_valid = 1'b0;
      k++;
      #1;
      if (b_ready) got = 1'b1;
    end
    tests++;
    if (!got || k != 1 + P + G + CHK) begin
      fails++; $display("FAIL arb_b_back_to_back: got %0d cycles expected %0d", k, 1 + P + G + CHK);
    end
    @(negedge clk);
    b_valid = 1'b0;
    k = 0;
    #1;
    while (!done && k < 20) begin
      @(negedge clk); #1; k++;
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL arb_b_done: got timeout expected done");
    end
    tests++;
    if (lat_q[1] !== 1'b0) begin
      fails++; $display("FAIL arb_final_latch: got %b expected 0", lat_q[1]);
    end
    @(negedge clk);
    a_valid = 1'b1; a_idx = 2'd3; a_op = 1'b1;
    b_valid = 1'b1; b_idx = 2'd0; b_op = 1'b0;
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      fails++; $display("FAIL arb_rr_back_to_a: got %b expected 10", {a_ready, b_ready});
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (P + G + CHK + 1) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    logic bad;
    apply_reset;
    @(negedge clk);
    a_valid = 1'b1; a_idx = 2'd0; a_op = 1'b0;
    #1;
    tests++;
    if (a_ready !== 1'b1) begin
      fails++; $display("FAIL mid_grant: got %b expected 1", a_ready);
    end
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    tests++;
    if ({s_n, r_n} !== 8'hFE) begin
      fails++; $display("FAIL mid_pulse_active: got %h expected fe", {s_n, r_n});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({s_n, r_n, busy} !== {8'hFF, 1'b0}) begin
      fails++; $display("FAIL mid_reset_release: got %h expected 1fe", {s_n, r_n, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (done || busy || s_n != 4'hF || r_n != 4'hF) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL mid_reset_no_replay: got activity expected quiet");
    end
  endtask

`ifdef VERIFY_READBACK_EN
  task automatic test_readback;
    int k;
    apply_reset;
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL rb_err_reset: got %b expected 0", err);
    end
    for (int op = 0; op < 2; op++) begin
      stuck0 = (op == 0);
      @(negedge clk);
      a_valid = 1'b1; a_idx = 2'(op); a_op = 1'b1;
      #1;
      tests++;
      if (a_ready !== 1'b1) begin
        fails++; $display("FAIL rb_grant%0d: got %b expected 1", op, a_ready);
      end
      @(negedge clk);
      a_valid = 1'b0;
      k = 0;
      #1;
      while (!done && k < 20) begin
        @(negedge clk); #1; k++;
      end
      @(negedge clk); #1;
      tests++;
      if (err !== 1'b1) begin
        fails++; $display("FAIL rb_err_sticky%0d: got %b expected 1", op, err);
      end
    end
    stuck0 = 1'b0;
  endtask
`endif

  task automatic test_random;
    int           gen, grants, done_cnt, cyc, free_at, g_cyc, k;
    logic         ptr, act, pa, pb, ao, bo, ea, eb, eg_op, exp_done, exp_busy;
    logic [IW-1:0] ai, bi, eg_idx;
    logic [N-1:0] exp_s, exp_r, exp_lat;
    apply_reset;
    gen = 0; grants = 0; done_cnt = 0; cyc = 0; free_at = 0; g_cyc = 0;
    ptr = 1'b0; act = 1'b0; pa = 1'b0; pb = 1'b0;
    ai = '0; bi = '0; ao = 1'b0; bo = 1'b0; eg_idx = '0; eg_op = 1'b0;
    exp_lat = lat_q;
    while ((gen < NOPS || pa || pb || cyc < free_at) && cyc < 40000) begin
      @(negedge clk);
      if (!pa && gen < NOPS && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; ai = IW'($urandom_range(0, N - 1)); ao = 1'($urandom_range(0, 1)); gen++;
      end
      if (!pb && gen < NOPS && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; bi = IW'($urandom_range(0, N - 1)); bo = 1'($urandom_range(0, 1)); gen++;
      end
      a_valid = pa; a_idx = ai; a_op = ao;
      b_valid = pb; b_idx = bi; b_op = bo;
      #1;
      ea = (cyc >= free_at) && pa && (!pb || !ptr);
      eb = (cyc >= free_at) && pb && !ea;
      k = cyc - g_cyc;
      exp_s = '1; exp_r = '1;
      if (act && k >= 1 && k <= P) begin
        if (eg_op) exp_s[eg_idx] = 1'b0;
        else       exp_r[eg_idx] = 1'b0;
      end
      exp_done = act && (k == P + G + CHK);
      exp_busy = act && (k >= 1) && (k <= P + G + CHK);
      tests++;
      if ({a_ready, b_ready, busy, done, s_n, r_n} !== {ea, eb, exp_busy, exp_done, exp_s, exp_r}) begin
        fails++;
        $display("FAIL rand_cycle%0d: got %h expected %h", cyc,
                 {a_ready, b_ready, busy, done, s_n, r_n}, {ea, eb, exp_busy, exp_done, exp_s, exp_r});
      end
      tests++;
      if ($countones(~{s_n, r_n}) > 1) begin
        fails++; $display("FAIL rand_invariant%0d: got %h expected at most one low", cyc, {s_n, r_n});
      end
      if (done) done_cnt++;
      if (ea || eb) begin
        act = 1'b1; g_cyc = cyc; free_at = cyc + P + G + CHK + 1; grants++;
        eg_idx = ea ? ai : bi;
        eg_op  = ea ? ao : bo;
        exp_lat[eg_idx] = eg_op;
        ptr = ea;
        if (ea) pa = 1'b0;
        else    pb = 1'b0;
      end
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tests++;
    if (grants != NOPS || done_cnt != grants) begin
      fails++; $display("FAIL rand_done_count: got grants %0d dones %0d expected %0d each", grants, done_cnt, NOPS);
    end
    tests++;
    if (lat_q !== exp_lat) begin
      fails++; $display("FAIL rand_latch_state: got %b expected %b", lat_q, exp_lat);
    end
  endtask

  initial begin
    test_reset;
    test_a_only;
    test_arbitration;
    test_mid_reset;
`ifdef VERIFY_READBACK_EN
    test_readback;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
